poyov: RTL and testbench
========================

// Module: poyov
// PURPOSE
// - Top of a 3-stage pipelined RV32I-subset CPU (IF | ID | EX/MEM/WB) with built-in program ROM, data RAM and a memory-mapped LED.
// - Fixed ROM program blinks LED: toggles LED, busy-waits DELAY loop iterations, repeats forever.
// - Single-clock FPGA demo top; only externally visible output is LED.
// PARAMETERS
// - DELAY       4    busy-wait loop count loaded by "addi x3,x0,DELAY"; legal 1..2047
// - DMEM_WORDS  256  data RAM depth, 32-bit words, byte addresses 0x000-0x3FF
// PORTS
// - clk  in  1  single system clock, all state on posedge
// - rst  in  1  synchronous, active-high reset
// - LED  out 1  registered LED bit, driven from memory-mapped register at LED_ADDR
// BEHAVIOUR
// - Reset (sync, active-high, checked on posedge): PC=0; IF/ID and ID/EX regs hold bubbles (valid=0); x1..x31=0; LED=0. DMEM is not reset.
// - Reset mid-operation: same as power-up. Execution restarts at PC=0 on the first posedge with rst=0.
// - ISA subset:
//   - LUI, JAL, JALR
//   - BEQ/BNE/BLT/BGE/BLTU/BGEU
//   - LW, SW (word only)
//   - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI
//   - ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND
//   - Any other encoding executes as NOP.
// - Arithmetic: 32-bit, wrap-around. Immediates sign-extended per RV32I. Shifts use the low 5 bits of the amount. Writes to x0 are discarded.
// - Pipeline:
//   - IF: fetch ROM[PC[9:2]], PC+=4.
//   - ID: decode and read regfile.
//   - EX: ALU, branch/jump resolve, DMEM/MMIO access, regfile write at end of cycle.
// - Hazards:
//   - Regfile is write-through: ID reads the same-cycle EX write data. No stalls are ever required.
//   - DMEM read is combinational in EX, so no load-use penalty.
// - Control flow: a taken branch or any jump in EX loads PC with the target and flushes IF/ID and ID/EX to bubbles. Penalty is 2 cycles; the not-taken path has none.
// - Memory map:
//   - SW to LED_ADDR (0x400) sets LED<=rs2[0] on that posedge.
//   - SW to any other address writes dmem[addr[9:2]].
//   - LW from LED_ADDR returns {31'b0,LED}; LW elsewhere returns dmem[addr[9:2]].
//   - addr[1:0] is ignored.
// - ROM program (word index: instruction):
//   - 0: addi x1,x0,0
//   - 1: addi x2,x0,0x400
//   - 2: sw x1,0(x2)
//   - 3: addi x3,x0,DELAY
//   - 4: addi x3,x3,-1
//   - 5: bne x3,x0,-4
//   - 6: xori x1,x1,1
//   - 7: jal x0,-20
//   - 8..255: NOP (addi x0,x0,0)
// - Resulting timing: consecutive LED-writing SWs are exactly 4*DELAY+4 cycles apart, so LED toggles every 4*DELAY+4 cycles.
// - The first SW (EX in cycle 5 after reset release) writes 0. The first rising edge of LED follows 4*DELAY+4 cycles later.
// STRUCTURE
// - Package poyov_pkg:
//   - opcode/funct3/funct7 localparams
//   - ALU-op enum
//   - LED_ADDR=32'h400
//   - NOP=32'h00000013
// - Sub-module poyov_regfile: 32x32, 2 combinational read ports, 1 write port, x0 hard-zero, write-through bypass.
// - ROM, DMEM, decoder, ALU, branch unit and pipeline regs stay inline in poyov.
// TESTING
// - Reset: hold rst 3 cycles, DELAY=4 -> LED=0 throughout. Release -> LED stays 0 for the first 4*DELAY+4+5 cycles, then rises.
// - Blink period, DELAY=4 -> LED edges exactly 20 cycles apart and alternating, checked over >=10 edges.
// - Boundary DELAY=1 -> edges 8 cycles apart. DELAY=2047 -> edges 8192 cycles apart.
// - Mid-run reset: pulse rst 1 cycle while LED=1 -> LED=0 after that posedge. First subsequent rise occurs at the same offset as after power-up.
// - poyov_regfile unit:
//   - write x5=0xDEADBEEF and read x5 in the same cycle -> 0xDEADBEEF
//   - write x0=0xFFFFFFFF -> x0 reads 0
// - Branch flush, via an alternate ROM image loaded through a test-only `define: taken BEQ followed by two ADDIs to x7 -> x7 unchanged (0). Not-taken path -> x7 updated.

Source files
------------

// File: rtl/poyov_pkg.sv
// poyov_pkg: shared encodings and helpers for the poyov RV32I-subset CPU.
// Holds opcode/funct3/funct7 constants, the ALU-op enum, the ID/EX pipeline
// register layout, the LED MMIO address, the canonical NOP and the pure ALU /
// branch-compare functions used in EX.
package poyov_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_W    = 3'd2;
  localparam logic [2:0] F3_SR   = 3'd5;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] LED_ADDR = 32'h0000_0400;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  // ID/EX register: operands are already selected in ID so EX is one ALU pass.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] a;    // ALU operand A (rs1, or 0 for LUI)
    logic [31:0] b;    // ALU operand B (immediate or rs2)
    logic [31:0] sd;   // rs2 value: store data and branch compare operand
    logic [31:0] off;  // PC-relative offset for branches and JAL
    logic [4:0]  rd;
    logic        we;
    logic [2:0]  f3;
    logic        br;
    logic        jal;
    logic        jalr;
    logic        ld;
    logic        st;
    alu_op_e     op;
  } idex_t;

  function automatic alu_op_e alu_dec(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a,
                                      input logic [31:0] b);
    case (op)
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a + b;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    case (f3)
      F3_BEQ:  return a == b;
      F3_BNE:  return a != b;
      F3_BLT:  return $signed(a) < $signed(b);
      F3_BGE:  return $signed(a) >= $signed(b);
      F3_BLTU: return a < b;
      F3_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/poyov_regfile.sv
// poyov_regfile: 32x32 integer register file.
// Ports: clk_i/rst_i (sync, active-high, clears x1..x31), two combinational
// read ports (ra*_i -> rd*_o), one write port (we_i, wa_i, wd_i).
// x0 always reads zero; a read of the register being written this cycle
// returns the write data, which lets ID see EX results without stalling.
module poyov_regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && wa_i != 5'd0) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    rd1_o = regs_q[ra1_i];
    rd2_o = regs_q[ra2_i];
    if (we_i && wa_i == ra1_i) rd1_o = wd_i;
    if (we_i && wa_i == ra2_i) rd2_o = wd_i;
    if (ra1_i == 5'd0) rd1_o = '0;
    if (ra2_i == 5'd0) rd2_o = '0;
  end

endmodule

// File: rtl/poyov.sv
// poyov: 3-stage (IF | ID | EX/MEM/WB) RV32I-subset CPU with built-in program
// ROM, data RAM and a memory-mapped LED register at LED_ADDR.
// Ports: clk (all state on posedge), rst (sync, active-high), LED (registered).
// The built-in program toggles LED, spins DELAY loop iterations and repeats,
// so LED toggles every 4*DELAY+4 cycles.
module poyov
  import poyov_pkg::*;
#(
  parameter int DELAY      = 4,
  parameter int DMEM_WORDS = 256,
  parameter bit ALT_ROM    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  output logic LED
);

  localparam int          AW    = $clog2(DMEM_WORDS);
  localparam logic [11:0] DLY12 = 12'(DELAY);
`ifdef POYOV_ALT_ROM
  localparam bit USE_ALT = 1'b1;
`else
  localparam bit USE_ALT = ALT_ROM;
`endif

  // Blink program, or the branch-flush exercise image when USE_ALT is set.
  function automatic logic [31:0] rom_word(input logic [7:0] idx);
    if (USE_ALT) begin
      case (idx)
        8'd0:    return 32'h0000_0663;  // beq  x0,x0,+12
        8'd1:    return 32'h0013_8393;  // addi x7,x7,1  (flushed)
        8'd2:    return 32'h0023_8393;  // addi x7,x7,2  (flushed)
        8'd3:    return 32'h0000_1463;  // bne  x0,x0,+8 (falls through)
        8'd4:    return 32'h0043_8393;  // addi x7,x7,4
        8'd5:    return 32'h0083_8393;  // addi x7,x7,8
        8'd6:    return 32'h0070_2823;  // sw   x7,16(x0)
        8'd7:    return 32'h0100_2403;  // lw   x8,16(x0)
        8'd8:    return 32'h0000_006F;  // jal  x0,0
        default: return NOP;
      endcase
    end else begin
      case (idx)
        8'd0:    return 32'h0000_0093;           // addi x1,x0,0
        8'd1:    return 32'h4000_0113;           // addi x2,x0,0x400
        8'd2:    return 32'h0011_2023;           // sw   x1,0(x2)
        8'd3:    return {DLY12, 20'h00193};      // addi x3,x0,DELAY
        8'd4:    return 32'hFFF1_8193;           // addi x3,x3,-1
        8'd5:    return 32'hFE01_9EE3;           // bne  x3,x0,-4
        8'd6:    return 32'h0010_C093;           // xori x1,x1,1
        8'd7:    return 32'hFEDF_F06F;           // jal  x0,-20
        default: return NOP;
      endcase
    end
  endfunction

  logic [31:0] pc_q, pc_d;
  logic [1:0]  vld_q, vld_d;  // [0] IF/ID valid, [1] ID/EX valid
  logic        led_q, led_d;
  logic [31:0] ifid_ir_q, ifid_pc_q;
  idex_t       idex_q, idex_d;
  logic [31:0] dmem_q [DMEM_WORDS];

  // ---------------- ID ----------------
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1v, rs2v;

  assign opc   = ifid_ir_q[6:0];
  assign f3    = ifid_ir_q[14:12];
  assign f7    = ifid_ir_q[31:25];
  assign imm_i = {{20{ifid_ir_q[31]}}, ifid_ir_q[31:20]};
  assign imm_s = {{20{ifid_ir_q[31]}}, ifid_ir_q[31:25], ifid_ir_q[11:7]};
  assign imm_b = {{19{ifid_ir_q[31]}}, ifid_ir_q[31], ifid_ir_q[7],
                  ifid_ir_q[30:25], ifid_ir_q[11:8], 1'b0};
  assign imm_u = {ifid_ir_q[31:12], 12'b0};
  assign imm_j = {{11{ifid_ir_q[31]}}, ifid_ir_q[31], ifid_ir_q[19:12],
                  ifid_ir_q[20], ifid_ir_q[30:21], 1'b0};

  // ---------------- EX ----------------
  logic        ex_v, redirect, led_hit, rf_we;
  logic [31:0] alu_y, target, rdata, wd;
  logic [AW-1:0] didx;

  assign ex_v     = vld_q[1];
  assign alu_y    = alu(idex_q.op, idex_q.a, idex_q.b);
  assign redirect = ex_v & (idex_q.jal | idex_q.jalr |
                            (idex_q.br & br_taken(idex_q.f3, idex_q.a, idex_q.sd)));
  assign target   = idex_q.jalr ? {alu_y[31:1], 1'b0} : idex_q.pc + idex_q.off;
  assign led_hit  = alu_y[31:2] == LED_ADDR[31:2];
  assign didx     = alu_y[AW+1:2];
  assign rdata    = led_hit ? {31'b0, led_q} : dmem_q[didx];
  assign wd       = idex_q.ld ? rdata :
                    (idex_q.jal | idex_q.jalr) ? idex_q.pc + 32'd4 : alu_y;
  assign rf_we    = ex_v & idex_q.we;

  poyov_regfile u_rf (
    .clk_i (clk),
    .rst_i (rst),
    .ra1_i (ifid_ir_q[19:15]),
    .ra2_i (ifid_ir_q[24:20]),
    .rd1_o (rs1v),
    .rd2_o (rs2v),
    .we_i  (rf_we),
    .wa_i  (idex_q.rd),
    .wd_i  (wd)
  );

  // Decode. Unsupported encodings leave every control bit clear (a NOP).
  always_comb begin
    idex_d     = '0;
    idex_d.op  = ALU_ADD;
    idex_d.pc  = ifid_pc_q;
    idex_d.a   = rs1v;
    idex_d.sd  = rs2v;
    idex_d.rd  = ifid_ir_q[11:7];
    idex_d.f3  = f3;
    case (opc)
      OP_LUI: begin
        idex_d.a  = '0;
        idex_d.b  = imm_u;
        idex_d.we = 1'b1;
      end
      OP_JAL: begin
        idex_d.jal = 1'b1;
        idex_d.we  = 1'b1;
        idex_d.off = imm_j;
      end
      OP_JALR: if (f3 == 3'd0) begin
        idex_d.jalr = 1'b1;
        idex_d.we   = 1'b1;
        idex_d.b    = imm_i;
      end
      OP_BR: if (f3 != 3'd2 && f3 != 3'd3) begin
        idex_d.br  = 1'b1;
        idex_d.off = imm_b;
      end
      OP_LOAD: if (f3 == F3_W) begin
        idex_d.ld = 1'b1;
        idex_d.we = 1'b1;
        idex_d.b  = imm_i;
      end
      OP_STORE: if (f3 == F3_W) begin
        idex_d.st = 1'b1;
        idex_d.b  = imm_s;
      end
      OP_IMM: if ((f3 != F3_SLL || f7 == F7_ZERO) &&
                  (f3 != F3_SR || f7 == F7_ZERO || f7 == F7_ALT)) begin
        idex_d.we = 1'b1;
        idex_d.b  = imm_i;
        // bit 30 only selects SRAI; for ADDI it is part of the immediate
        idex_d.op = alu_dec(f3, f3 == F3_SR && f7 == F7_ALT);
      end
      OP_REG: if (f7 == F7_ZERO ||
                  (f7 == F7_ALT && (f3 == 3'd0 || f3 == F3_SR))) begin
        idex_d.we = 1'b1;
        idex_d.b  = rs2v;
        idex_d.op = alu_dec(f3, f7 == F7_ALT);
      end
      default: ;
    endcase
  end

  // PC / valid / LED next state. A redirect kills both younger stages.
  always_comb begin
    pc_d  = pc_q + 32'd4;
    vld_d = {vld_q[0], 1'b1};
    led_d = led_q;
    if (redirect) begin
      pc_d  = target;
      vld_d = 2'b00;
    end
    if (ex_v && idex_q.st && led_hit) led_d = idex_q.sd[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= '0;
      vld_q <= '0;
      led_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      vld_q <= vld_d;
      led_q <= led_d;
    end
  end

  // Payload registers: their contents are ignored while the matching valid is low.
  always_ff @(posedge clk) begin
    ifid_ir_q <= rom_word(pc_q[9:2]);
    ifid_pc_q <= pc_q;
    idex_q    <= idex_d;
  end

  always_ff @(posedge clk) begin
    if (!rst && ex_v && idex_q.st && !led_hit) dmem_q[didx] <= idex_q.sd;
  end

  assign LED = led_q;

endmodule

// File: tb/tb_poyov.sv
module tb_poyov;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4 = 1'b1, rst1 = 1'b1, rst2k = 1'b1, rsta = 1'b1;
  logic led4, led1, led2k, leda;
  int errs = 0, checks = 0;

  logic        rf_rst = 1'b1, rf_we = 1'b0;
  logic [4:0]  rf_ra1 = '0, rf_ra2 = '0, rf_wa = '0;
  logic [31:0] rf_wd = '0, rf_rd1, rf_rd2;

  poyov #(.DELAY(4))    dut4  (.clk(clk), .rst(rst4),  .LED(led4));
  poyov #(.DELAY(1))    dut1  (.clk(clk), .rst(rst1),  .LED(led1));
  poyov #(.DELAY(2047)) dut2k (.clk(clk), .rst(rst2k), .LED(led2k));
  poyov #(.DELAY(4), .ALT_ROM(1'b1)) dut_alt (.clk(clk), .rst(rsta), .LED(leda));

  poyov_regfile u_rf_tb (
    .clk_i(clk), .rst_i(rf_rst), .ra1_i(rf_ra1), .ra2_i(rf_ra2),
    .rd1_o(rf_rd1), .rd2_o(rf_rd2), .we_i(rf_we), .wa_i(rf_wa), .wd_i(rf_wd)
  );

  function automatic logic sel_led(input int w);
    case (w)
      0:       return led4;
      1:       return led1;
      default: return led2k;
    endcase
  endfunction

  // Counts negedges until the selected LED changes; cyc=0 means the budget ran out.
  task automatic wait_edge(input int w, input int budget, output int cyc, output logic val);
    logic prev;
    bit   done;
    prev = sel_led(w);
    val  = prev;
    cyc  = 0;
    done = 0;
    for (int i = 1; i <= budget && !done; i++) begin
      @(negedge clk);
      if (sel_led(w) !== prev) begin
        cyc  = i;
        val  = sel_led(w);
        done = 1;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (led4 !== 1'b0) begin errs++; $display("FAIL reset_hold: LED=%b want 0", led4); end
    end
    rst4 = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      checks++;
      if (led4 !== 1'b0) begin errs++; $display("FAIL early_low cyc %0d: LED=%b want 0", n, led4); end
    end
    @(negedge clk);
    checks++;
    if (led4 !== 1'b1) begin errs++; $display("FAIL first_rise cyc 25: LED=%b want 1", led4); end
  endtask

  task automatic test_blink();
    int cyc;
    logic val, exp_v;
    exp_v = 1'b0;
    for (int e = 0; e < 10; e++) begin
      wait_edge(0, 40, cyc, val);
      checks++;
      if (cyc != 20 || val !== exp_v) begin
        errs++;
        $display("FAIL blink edge %0d: gap=%0d val=%b want gap=20 val=%b", e, cyc, val, exp_v);
      end
      exp_v = ~exp_v;
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    logic val;
    checks++;
    if (led4 !== 1'b1) begin errs++; $display("FAIL pre_reset_led: LED=%b want 1", led4); end
    rst4 = 1'b1;
    @(negedge clk);
    checks++;
    if (led4 !== 1'b0) begin errs++; $display("FAIL mid_reset_clear: LED=%b want 0", led4); end
    rst4 = 1'b0;
    wait_edge(0, 60, cyc, val);
    checks++;
    if (cyc != 25 || val !== 1'b1) begin
      errs++; $display("FAIL mid_reset_rise: gap=%0d val=%b want gap=25 val=1", cyc, val);
    end
  endtask

  task automatic test_delay1();
    int cyc;
    logic val, exp_v;
    rst1 = 1'b0;
    wait_edge(1, 40, cyc, val);
    checks++;
    if (cyc != 13 || val !== 1'b1) begin
      errs++; $display("FAIL d1_first_rise: gap=%0d val=%b want gap=13 val=1", cyc, val);
    end
    exp_v = 1'b0;
    for (int e = 0; e < 4; e++) begin
      wait_edge(1, 20, cyc, val);
      checks++;
      if (cyc != 8 || val !== exp_v) begin
        errs++; $display("FAIL d1_edge %0d: gap=%0d val=%b want gap=8 val=%b", e, cyc, val, exp_v);
      end
      exp_v = ~exp_v;
    end
  endtask

  task automatic test_delay2047();
    int cyc;
    logic val, exp_v;
    rst2k = 1'b0;
    wait_edge(2, 8300, cyc, val);
    checks++;
    if (cyc != 8197 || val !== 1'b1) begin
      errs++; $display("FAIL d2047_first_rise: gap=%0d val=%b want gap=8197 val=1", cyc, val);
    end
    exp_v = 1'b0;
    for (int e = 0; e < 2; e++) begin
      wait_edge(2, 8300, cyc, val);
      checks++;
      if (cyc != 8192 || val !== exp_v) begin
        errs++; $display("FAIL d2047_edge %0d: gap=%0d val=%b want gap=8192 val=%b", e, cyc, val, exp_v);
      end
      exp_v = ~exp_v;
    end
  endtask

  task automatic test_branch_flush();
    rsta = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (dut_alt.u_rf.regs_q[7] !== 32'd0) begin
      errs++; $display("FAIL flush_taken: x7=%0d want 0", dut_alt.u_rf.regs_q[7]);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (dut_alt.u_rf.regs_q[7] !== 32'd4) begin
      errs++; $display("FAIL not_taken_path: x7=%0d want 4", dut_alt.u_rf.regs_q[7]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (dut_alt.u_rf.regs_q[7] !== 32'd12) begin
      errs++; $display("FAIL x7_final: x7=%0d want 12", dut_alt.u_rf.regs_q[7]);
    end
    checks++;
    if (dut_alt.u_rf.regs_q[8] !== 32'd12) begin
      errs++; $display("FAIL sw_lw: x8=%0d want 12", dut_alt.u_rf.regs_q[8]);
    end
  endtask

  task automatic test_regfile();
    @(negedge clk);
    rf_rst = 1'b0;
    rf_ra1 = 5'd5;
    #1;
    checks++;
    if (rf_rd1 !== 32'd0) begin errs++; $display("FAIL rf_reset: x5=%h want 0", rf_rd1); end
    rf_we = 1'b1; rf_wa = 5'd5; rf_wd = 32'hDEADBEEF; rf_ra2 = 5'd5;
    #1;
    checks++;
    if (rf_rd1 !== 32'hDEADBEEF || rf_rd2 !== 32'hDEADBEEF) begin
      errs++; $display("FAIL rf_bypass: rd1=%h rd2=%h want deadbeef", rf_rd1, rf_rd2);
    end
    @(negedge clk);
    rf_we = 1'b0;
    #1;
    checks++;
    if (rf_rd1 !== 32'hDEADBEEF) begin errs++; $display("FAIL rf_stored: x5=%h want deadbeef", rf_rd1); end
    rf_we = 1'b1; rf_wa = 5'd0; rf_wd = 32'hFFFFFFFF; rf_ra1 = 5'd0;
    #1;
    checks++;
    if (rf_rd1 !== 32'd0) begin errs++; $display("FAIL rf_x0_bypass: x0=%h want 0", rf_rd1); end
    @(negedge clk);
    rf_we = 1'b0;
    #1;
    checks++;
    if (rf_rd1 !== 32'd0) begin errs++; $display("FAIL rf_x0_stored: x0=%h want 0", rf_rd1); end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_mid_reset();
    test_delay1();
    test_branch_flush();
    test_regfile();
    test_delay2047();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
